// File: rtl/branch_pkg.sv
// Shared constants for the EX-stage branch resolution controller: comparator
// encodings, RISC-V branch funct3 values, FSM state type and small helpers.
package branch_pkg;

    localparam logic [2:0] BR_EQ   = 3'b000;
    localparam logic [2:0] BR_NE   = 3'b001;
    localparam logic [2:0] BR_LT   = 3'b010;
    localparam logic [2:0] BR_GE   = 3'b011;
    localparam logic [2:0] BR_LTU  = 3'b100;
    localparam logic [2:0] BR_GEU  = 3'b101;
    localparam logic [2:0] BR_NONE = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // A redirect target must be word aligned; low two bits flag a fault.
    function automatic logic target_misaligned(input logic [31:0] target);
        return (target[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/branch_ctrl_br_decode.sv
// Combinational funct3 -> comparator operation map, shared with decode logic.
module br_decode
    import branch_pkg::*;
(
    input  logic [2:0] funct3,
    output logic [2:0] br_type
);

    // Unused funct3 codes select an operation the comparator never takes.
    always_comb begin
        br_type = BR_NONE;
        case (funct3)
            F3_BEQ:  br_type = BR_EQ;
            F3_BNE:  br_type = BR_NE;
            F3_BLT:  br_type = BR_LT;
            F3_BGE:  br_type = BR_GE;
            F3_BLTU: br_type = BR_LTU;
            F3_BGEU: br_type = BR_GEU;
            default: br_type = BR_NONE;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: qualifies comparator result, issues a registered
// PC redirect, squashes IF/ID for a fixed window and keeps branch statistics.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_ex,
    input  logic             is_branch,
    input  logic             is_jump,
    input  logic [2:0]       funct3,
    input  logic             br_taken,
    input  logic             stall,
    input  logic [31:0]      br_target,
    output logic [2:0]       br_type,
    output logic             pc_sel,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             misalign,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [2:0]       FLUSH_LOAD = FLUSH_CYCLES[2:0];
    localparam logic [2:0]       FCNT_ONE   = 3'd1;
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_r;
    logic [2:0]        flush_cnt_r;
    logic              pc_sel_r;
    logic [31:0]       redirect_pc_r;
    logic              flush_r;
    logic              misalign_r;
    logic [CNT_W-1:0]  branch_cnt_r;
    logic [CNT_W-1:0]  taken_cnt_r;
    logic              resolve_s;
    logic              take_s;
    logic              count_branch_s;

    br_decode u_br_decode (
        .funct3  (funct3),
        .br_type (br_type)
    );

    // A jump that is also flagged as a branch is treated purely as a jump.
    assign resolve_s      = valid_ex & ~stall & (state_r == RUN) & (is_branch | is_jump);
    assign take_s         = resolve_s & (is_jump | (is_branch & br_taken));
    assign count_branch_s = resolve_s & is_branch & ~is_jump;

    // Redirect/squash FSM: one pc_sel cycle, flush held until the window drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= RUN;
            flush_cnt_r   <= 3'd0;
            pc_sel_r      <= 1'b0;
            redirect_pc_r <= 32'h0000_0000;
            flush_r       <= 1'b0;
            misalign_r    <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (take_s) begin
                        state_r       <= FLUSH;
                        flush_cnt_r   <= FLUSH_LOAD;
                        pc_sel_r      <= 1'b1;
                        redirect_pc_r <= br_target;
                        flush_r       <= 1'b1;
                        misalign_r    <= target_misaligned(br_target);
                    end else begin
                        pc_sel_r      <= 1'b0;
                        flush_r       <= 1'b0;
                        misalign_r    <= 1'b0;
                    end
                end
                FLUSH: begin
                    pc_sel_r   <= 1'b0;
                    misalign_r <= 1'b0;
                    if (!stall) begin
                        if (flush_cnt_r <= FCNT_ONE) begin
                            state_r     <= RUN;
                            flush_cnt_r <= 3'd0;
                            flush_r     <= 1'b0;
                        end else begin
                            flush_cnt_r <= flush_cnt_r - FCNT_ONE;
                        end
                    end
                end
                default: begin
                    state_r     <= RUN;
                    flush_cnt_r <= 3'd0;
                    pc_sel_r    <= 1'b0;
                    flush_r     <= 1'b0;
                    misalign_r  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics; only resolved instructions are counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt_r <= {CNT_W{1'b0}};
            taken_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (count_branch_s && (branch_cnt_r != CNT_MAX)) begin
                branch_cnt_r <= branch_cnt_r + CNT_ONE;
            end
            if (take_s && (taken_cnt_r != CNT_MAX)) begin
                taken_cnt_r <= taken_cnt_r + CNT_ONE;
            end
        end
    end

    assign pc_sel      = pc_sel_r;
    assign redirect_pc = redirect_pc_r;
    assign flush       = flush_r;
    assign misalign    = misalign_r;
    assign branch_cnt  = branch_cnt_r;
    assign taken_cnt   = taken_cnt_r;

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Execute-stage branch resolution controller for the 3-stage pipeline.
- Drives the comparator's br_type encoding from instruction funct3.
- Qualifies the comparator's br_taken result with valid, branch/jump and stall.
- Issues a registered PC redirect, holds fetch/decode flush for a fixed squash window and keeps saturating branch statistics.

Parameters:
- FLUSH_CYCLES, 2, cycles flush is held after a redirect; legal range 1..7.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- valid_ex  input  1  EX-stage instruction valid
- is_branch  input  1  EX instruction is a conditional branch
- is_jump  input  1  EX instruction is JAL/JALR
- funct3  input  3  EX instruction funct3
- br_taken  input  1  comparator result for the current br_type
- stall  input  1  pipeline stall; EX contents held
- br_target  input  32  computed branch/jump target
- br_type  output  3  comparator operation select
- pc_sel  output  1  1 = fetch from redirect_pc
- redirect_pc  output  32  latched target
- flush  output  1  squash IF/ID pipeline registers
- misalign  output  1  one-cycle pulse: target[1:0] != 0 on a redirect
- branch_cnt  output  CNT_W  resolved conditional branches
- taken_cnt  output  CNT_W  redirects issued, branches and jumps

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values: state=RUN, pc_sel=0, redirect_pc=0, flush=0, misalign=0, both counters=0, flush counter=0.
- br_type decode is combinational and independent of state:
  - funct3 000→000, 001→001, 100→010, 101→011, 110→100, 111→101.
  - funct3 010/011→111 (never taken).
- resolve = valid_ex & !stall & state==RUN & (is_branch | is_jump).
- take = resolve & (is_jump | (is_branch & br_taken)).
- is_jump has priority: if is_jump & is_branch, treat as jump.
- Latency: take in cycle N gives pc_sel=1, flush=1 and redirect_pc=br_target (as sampled in N) in cycle N+1.
  - misalign pulses in N+1 if br_target[1:0] != 0.
  - The redirect is still issued.
- FSM states RUN and FLUSH:
  - RUN→FLUSH on take; flush counter loads FLUSH_CYCLES.
  - In FLUSH: flush=1.
  - pc_sel=1 only in the first FLUSH cycle; 0 thereafter.
  - Counter decrements only when !stall. Stall freezes both flush and the counter.
  - FLUSH→RUN when the counter reaches 1 and !stall; flush=0 from the next cycle.
- While in FLUSH, valid_ex/is_branch/is_jump/br_taken are ignored (wrong-path squash). No take and no counting.
- Counters: update only on resolve.
  - branch_cnt += 1 when is_branch & !is_jump.
  - taken_cnt += 1 on take.
  - Both saturate at 2^CNT_W−1; no wrap.
- Stall in RUN: no resolve, no count, no redirect. The same instruction resolves exactly once, on the first non-stalled cycle.
- Not-taken branch: counted in branch_cnt only. No pc_sel, no flush.
- Reset mid-FLUSH: immediate return to RUN with all outputs at reset values on the next edge.
- redirect_pc holds its value until the next take.

Decomposition:
- Shared package branch_pkg holds:
  - br_type localparams: BR_EQ=000, BR_NE=001, BR_LT=010, BR_GE=011, BR_LTU=100, BR_GEU=101, BR_NONE=111.
  - RISC-V funct3 constants.
  - FSM enum state_e {RUN, FLUSH}.
- Optional sub-module br_decode: the combinational funct3→br_type map, reusable by decode-stage logic.
- Everything else stays flat.

Test Plan:
- Reset: hold rst_n=0 two cycles with valid_ex=1, is_jump=1 → pc_sel=0, flush=0, both counters 0 after release.
- BEQ taken: funct3=000, br_taken=1, br_target=0x0000_0100 at cycle N →
  - br_type=000 in N.
  - N+1: pc_sel=1, redirect_pc=0x100, flush=1.
  - N+2: flush=1, pc_sel=0.
  - N+3: flush=0.
  - branch_cnt=1, taken_cnt=1.
- BLTU not taken: funct3=110, br_taken=0 → br_type=100, no pc_sel/flush, branch_cnt=1, taken_cnt=0.
- Stall interaction:
  - JAL with stall=1 for 3 cycles then 0 → redirect one cycle after stall drops; taken_cnt=1, branch_cnt=0.
  - stall=1 during FLUSH extends flush by the stall length.
- Squash: taken branch, then valid_ex=1, is_branch=1, br_taken=1 in both following cycles → ignored; counters stay 1/1.
- Saturation and misalign: CNT_W=4, 20 taken jumps → taken_cnt=15. Target 0x0000_0102 → misalign pulse in the redirect cycle.
